// File: rtl/dca_matrix_lsu_store_unpacker.sv
// Store-path unpacker: expands packed row-buffer rows (2^lsa-bit columns) into
// 32-bit LSU columns with per-column strobes, through one bubble-free output register.
module dca_matrix_lsu_store_unpacker #(
  parameter int LSU_PARA         = 0,
  parameter int AXI_PARA         = 32,
  parameter int MATRIX_SIZE_PARA = 4,
  localparam int MATRIX_NUM_COL       = MATRIX_SIZE_PARA,
  localparam int BW_LSU_ELEMENT       = 32,
  localparam int BW_LSU_ELEMENT_ROW   = MATRIX_NUM_COL * BW_LSU_ELEMENT,
  localparam int BW_MEMORY_ROW_BUFFER = MATRIX_NUM_COL * 32,
  localparam int BW_TXN_INFO          = 2 * MATRIX_NUM_COL,
  localparam int BW_DCA_MATRIX_INFO_NUM_ROW_M1 = (MATRIX_SIZE_PARA > 1) ? $clog2(MATRIX_SIZE_PARA) : 1,
  localparam int BW_NUM_COL_M1        = BW_DCA_MATRIX_INFO_NUM_ROW_M1,
  localparam int BW_OPCODE            = (LSU_PARA == 0) ? 2 : 4,
  localparam int BW_ADDR              = AXI_PARA,
  localparam int BW_STRIDE_LS3        = AXI_PARA / 2,
  localparam int BW_LSA               = 3,
  localparam int OFS_ADDR             = BW_OPCODE,
  localparam int OFS_STRIDE           = OFS_ADDR + BW_ADDR,
  localparam int OFS_NUM_ROW          = OFS_STRIDE + BW_STRIDE_LS3,
  localparam int OFS_NUM_COL          = OFS_NUM_ROW + BW_DCA_MATRIX_INFO_NUM_ROW_M1,
  localparam int OFS_SIGNED           = OFS_NUM_COL + BW_NUM_COL_M1,
  localparam int OFS_FLOAT            = OFS_SIGNED + 1,
  localparam int OFS_LSA              = OFS_FLOAT + 1,
  localparam int OFS_MASK             = OFS_LSA + BW_LSA,
  localparam int BW_WINST_INFO        = OFS_MASK + MATRIX_NUM_COL
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            winst_valid,
  output logic                            winst_ready,
  input  logic [BW_WINST_INFO-1:0]        winst_info,
  input  logic                            rbuf_valid,
  output logic                            rbuf_ready,
  input  logic [BW_MEMORY_ROW_BUFFER-1:0] rbuf_data,
  input  logic [BW_TXN_INFO-1:0]          rbuf_txn_info,
  output logic                            wrow_valid,
  input  logic                            wrow_ready,
  output logic [BW_LSU_ELEMENT_ROW-1:0]   wrow_data,
  output logic [MATRIX_NUM_COL-1:0]       wrow_strb,
  output logic                            wrow_last,
  output logic [BW_TXN_INFO-1:0]          wrow_txn_info
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;
  localparam int SHW = $clog2(BW_MEMORY_ROW_BUFFER) + 1;

  logic [0:0]                             state_q, state_d;
  logic [BW_WINST_INFO-1:0]               info_q, info_d;
  logic [BW_DCA_MATRIX_INFO_NUM_ROW_M1-1:0] row_cnt_q, row_cnt_d;

  logic                                   wrow_valid_q;
  logic [BW_LSU_ELEMENT_ROW-1:0]          wrow_data_q;
  logic [MATRIX_NUM_COL-1:0]              wrow_strb_q;
  logic                                   wrow_last_q;
  logic [BW_TXN_INFO-1:0]                 wrow_txn_q;

  logic [MATRIX_NUM_COL-1:0]              col_mask;
  logic [BW_LSA-1:0]                      lsa_raw, lsa_eff;
  logic                                   is_signed;
  logic [BW_NUM_COL_M1-1:0]               num_col_m1;
  logic [BW_DCA_MATRIX_INFO_NUM_ROW_M1-1:0] num_row_m1;

  logic                                   winst_hs, rbuf_hs, row_last;
  logic [BW_LSU_ELEMENT_ROW-1:0]          unpacked_data;
  logic [MATRIX_NUM_COL-1:0]              unpacked_strb;
  logic [BW_MEMORY_ROW_BUFFER-1:0]        shifted;
  logic [SHW-1:0]                         shamt;

  // Opcode, address, stride and float flag ride along but never shape the data.
  logic unused_info;
  assign unused_info = ^{info_q[OFS_NUM_ROW-1:0], info_q[OFS_FLOAT]};

  assign col_mask   = info_q[OFS_MASK +: MATRIX_NUM_COL];
  assign lsa_raw    = info_q[OFS_LSA +: BW_LSA];
  assign is_signed  = info_q[OFS_SIGNED];
  assign num_col_m1 = info_q[OFS_NUM_COL +: BW_NUM_COL_M1];
  assign num_row_m1 = info_q[OFS_NUM_ROW +: BW_DCA_MATRIX_INFO_NUM_ROW_M1];
  assign lsa_eff    = (lsa_raw > 3'd5) ? 3'd5 : lsa_raw;

  assign winst_ready = (state_q == IDLE);
  assign rbuf_ready  = (state_q == ACTIVE) && (!wrow_valid_q || wrow_ready);
  assign winst_hs    = winst_valid && winst_ready;
  assign rbuf_hs     = rbuf_valid && rbuf_ready;
  assign row_last    = (row_cnt_q == num_row_m1);

  // 1-bit columns are always zero-extended; wider ones follow is_signed.
  function automatic logic [BW_LSU_ELEMENT-1:0] extend_col(
    input logic [BW_LSU_ELEMENT-1:0] raw,
    input logic [BW_LSA-1:0]         lsa,
    input logic                      sgn
  );
    logic [BW_LSU_ELEMENT-1:0] keep;
    logic [4:0]                msb_idx;
    keep    = (lsa >= 3'd5) ? '1 : ((32'd1 << (6'd1 << lsa)) - 32'd1);
    msb_idx = 5'((6'd1 << lsa) - 6'd1);
    if (sgn && (lsa != '0) && raw[msb_idx]) return raw | ~keep;
    else                                     return raw & keep;
  endfunction

  always_comb begin
    unpacked_data = '0;
    unpacked_strb = '0;
    shifted       = '0;
    shamt         = '0;
    for (int i = 0; i < MATRIX_NUM_COL; i++) begin
      shamt            = SHW'(i) << lsa_eff;
      shifted          = rbuf_data >> shamt;
      unpacked_strb[i] = col_mask[i] && (i <= int'(num_col_m1));
      if (unpacked_strb[i])
        unpacked_data[BW_LSU_ELEMENT*i +: BW_LSU_ELEMENT] =
          extend_col(shifted[BW_LSU_ELEMENT-1:0], lsa_eff, is_signed);
    end
  end

  always_comb begin
    state_d   = state_q;
    info_d    = info_q;
    row_cnt_d = row_cnt_q;
    case (state_q)
      IDLE: begin
        if (winst_hs) begin
          info_d    = winst_info;
          row_cnt_d = '0;
          state_d   = ACTIVE;
        end
      end
      default: begin
        if (rbuf_hs) begin
          row_cnt_d = row_cnt_q + 1'b1;
          if (row_last) state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      info_q    <= '0;
      row_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      info_q    <= info_d;
      row_cnt_q <= row_cnt_d;
    end
  end

  // Output register: loading a new row and draining the old one happen in the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrow_valid_q <= 1'b0;
      wrow_data_q  <= '0;
      wrow_strb_q  <= '0;
      wrow_last_q  <= 1'b0;
      wrow_txn_q   <= '0;
    end else if (rbuf_hs) begin
      wrow_valid_q <= 1'b1;
      wrow_data_q  <= unpacked_data;
      wrow_strb_q  <= unpacked_strb;
      wrow_last_q  <= row_last;
      wrow_txn_q   <= rbuf_txn_info;
    end else if (wrow_ready) begin
      wrow_valid_q <= 1'b0;
    end
  end

  assign wrow_valid    = wrow_valid_q;
  assign wrow_data     = wrow_data_q;
  assign wrow_strb     = wrow_strb_q;
  assign wrow_last     = wrow_last_q;
  assign wrow_txn_info = wrow_txn_q;

endmodule

// File: tb/tb_dca_matrix_lsu_store_unpacker.sv
// Randomized bench for the store unpacker: an arithmetic column model feeds an
// expected-row queue that a monitor drains on every output handshake.
module tb_dca_matrix_lsu_store_unpacker;

  localparam int NC = 4;
  localparam int RW = 128;
  localparam int TW = 8;
  localparam int IW = 63;

  logic          clk = 1'b0;
  logic          rst;
  logic          winst_valid;
  logic          winst_ready;
  logic [IW-1:0] winst_info;
  logic          rbuf_valid;
  logic          rbuf_ready;
  logic [RW-1:0] rbuf_data;
  logic [TW-1:0] rbuf_txn_info;
  logic          wrow_valid;
  logic          wrow_ready;
  logic [RW-1:0] wrow_data;
  logic [NC-1:0] wrow_strb;
  logic          wrow_last;
  logic [TW-1:0] wrow_txn_info;

  dca_matrix_lsu_store_unpacker dut (
    .clk          (clk),
    .rst          (rst),
    .winst_valid  (winst_valid),
    .winst_ready  (winst_ready),
    .winst_info   (winst_info),
    .rbuf_valid   (rbuf_valid),
    .rbuf_ready   (rbuf_ready),
    .rbuf_data    (rbuf_data),
    .rbuf_txn_info(rbuf_txn_info),
    .wrow_valid   (wrow_valid),
    .wrow_ready   (wrow_ready),
    .wrow_data    (wrow_data),
    .wrow_strb    (wrow_strb),
    .wrow_last    (wrow_last),
    .wrow_txn_info(wrow_txn_info)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [RW-1:0] data;
    logic [NC-1:0] strb;
    logic          last;
    logic [TW-1:0] txn;
  } exp_t;

  exp_t expq[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   hs_cyc = 0;
  int   m_lsa, m_ncol, m_nrow, m_row;
  bit   m_sgn;
  logic [NC-1:0] m_mask;
  bit   rdy_rand = 0;
  bit   mon_en = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Column i is the i-th W-bit slice, W = 2^min(lsa,5); signed values are offset by -2^W.
  function automatic exp_t model_row(input logic [RW-1:0] d, input logic [TW-1:0] txn, input bit last);
    exp_t e;
    int lsa, w;
    longint unsigned v;
    logic [RW-1:0] s;
    lsa = (m_lsa > 5) ? 5 : m_lsa;
    w = 1 << lsa;
    e.data = '0;
    e.strb = '0;
    e.last = last;
    e.txn  = txn;
    for (int i = 0; i < NC; i++) begin
      s = d >> (w * i);
      v = s[63:0] & ((64'd1 << w) - 64'd1);
      if (m_sgn && lsa >= 1 && v >= (64'd1 << (w - 1))) v = v - (64'd1 << w);
      if (m_mask[i] && i <= m_ncol) begin
        e.strb[i] = 1'b1;
        e.data[32*i +: 32] = v[31:0];
      end
    end
    return e;
  endfunction

  always @(posedge clk) begin
    #1;
    if (rdy_rand) wrow_ready = ($urandom_range(0, 3) != 0);
  end

  logic          held = 1'b0;
  logic [RW-1:0] h_data;
  logic [NC-1:0] h_strb;
  logic          h_last;
  logic [TW-1:0] h_txn;

  always @(negedge clk) begin
    if (rst || !mon_en) begin
      held = 1'b0;
    end else begin
      if (held) begin
        check("hold_valid", wrow_valid, 1'b1);
        check("hold_data", wrow_data, h_data);
        check("hold_side", {wrow_strb, wrow_last, wrow_txn_info}, {h_strb, h_last, h_txn});
      end
      if (wrow_valid && wrow_ready) begin
        held = 1'b0;
        if (expq.size() == 0) check("extra_row", 1'b1, 1'b0);
        else begin
          mon_e = expq.pop_front();
          check("row_data", wrow_data, mon_e.data);
          check("row_strb", wrow_strb, mon_e.strb);
          check("row_last", wrow_last, mon_e.last);
          check("row_txn", wrow_txn_info, mon_e.txn);
        end
      end else if (wrow_valid) begin
        held = 1'b1;
        h_data = wrow_data; h_strb = wrow_strb; h_last = wrow_last; h_txn = wrow_txn_info;
      end else begin
        held = 1'b0;
      end
    end
  end

  task automatic send_inst(input int lsa, input bit sgn, input bit flt, input int ncol,
                           input int nrow, input logic [NC-1:0] mask);
    bit ok = 0;
    int t = 0;
    m_lsa = lsa; m_sgn = sgn; m_ncol = ncol; m_nrow = nrow; m_mask = mask; m_row = 0;
    winst_info = {mask, 3'(lsa), flt, sgn, 2'(ncol), 2'(nrow), 16'($urandom),
                  32'($urandom), 2'($urandom)};
    winst_valid = 1'b1;
    while (!ok && t < 200) begin
      @(negedge clk);
      if (winst_ready) ok = 1;
      else begin @(posedge clk); #1; t++; end
    end
    if (!ok) check("inst_timeout", 1'b0, 1'b1);
    @(posedge clk); #1;
    winst_valid = 1'b0;
    winst_info  = {$urandom, $urandom};
  endtask

  task automatic send_row(input logic [RW-1:0] d, input logic [TW-1:0] txn);
    bit ok = 0;
    int t = 0;
    rbuf_data = d; rbuf_txn_info = txn; rbuf_valid = 1'b1;
    while (!ok && t < 200) begin
      @(negedge clk);
      if (rbuf_ready) ok = 1;
      else begin @(posedge clk); #1; t++; end
    end
    if (!ok) check("row_timeout", 1'b0, 1'b1);
    else begin
      expq.push_back(model_row(d, txn, m_row == m_nrow));
      m_row++;
      hs_cyc = cyc;
    end
    @(posedge clk); #1;
    rbuf_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((expq.size() != 0 || wrow_valid) && t < 500) begin
      @(negedge clk); t++;
    end
    if (t >= 500) check("drain_timeout", 1'b0, 1'b1);
    @(posedge clk); #1;
  endtask

  function automatic logic [RW-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_cyc;
    rst = 1'b1; winst_valid = 1'b0; winst_info = '0; rbuf_valid = 1'b0;
    rbuf_data = '0; rbuf_txn_info = '0; wrow_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_winst_ready", winst_ready, 1'b1);
    check("rst_rbuf_ready", rbuf_ready, 1'b0);
    check("rst_wrow_valid", wrow_valid, 1'b0);
    check("rst_wrow_data", wrow_data, '0);
    check("rst_wrow_side", {wrow_strb, wrow_last, wrow_txn_info}, '0);
    @(posedge clk); #1;
    rst = 1'b0; mon_en = 1;

    // signed bytes, single row held in the output register
    send_inst(3, 1, 0, 3, 0, 4'hF);
    send_row(128'h807F01FF, 8'h35);
    @(negedge clk);
    check("byte_signed_data", wrow_data, 128'hFFFFFF80_0000007F_00000001_FFFFFFFF);
    check("byte_signed_last", wrow_last, 1'b1);
    check("byte_signed_idle", winst_ready, 1'b1);
    @(posedge clk); #1; wrow_ready = 1'b1;
    drain();

    // unsigned nibbles, columns past num_col_m1 suppressed
    send_inst(2, 0, 0, 1, 0, 4'hF);
    send_row(128'hFFFF, 8'h36);
    @(negedge clk);
    check("nibble_data", wrow_data, 128'h0000000F_0000000F);
    check("nibble_strb", wrow_strb, 4'b0011);
    drain();

    // oversized lsa clamps to 32-bit columns
    send_inst(7, 1, 1, 0, 0, 4'h1);
    send_row(128'h80000000, 8'h38);
    @(negedge clk);
    check("lsa7_data", wrow_data, 128'h80000000);
    drain();

    // 1-bit columns never sign-extend
    send_inst(0, 1, 0, 3, 0, 4'hF);
    send_row(128'h5, 8'h39);
    @(negedge clk);
    check("lsa0_data", wrow_data, 128'h00000000_00000001_00000000_00000001);
    drain();

    // downstream stall after the first of three rows
    wrow_ready = 1'b0;
    send_inst(4, 1, 0, 3, 2, 4'hF);
    send_row(rnd128(), 8'hA0);
    rbuf_data = rnd128(); rbuf_txn_info = 8'hA1; rbuf_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("stall_rbuf_ready", rbuf_ready, 1'b0);
    end
    @(posedge clk); #1; wrow_ready = 1'b1;
    send_row(rbuf_data, 8'hA1);
    send_row(rnd128(), 8'hA2);
    drain();

    // back-to-back rows at full rate
    send_inst(5, 0, 0, 3, 3, 4'hF);
    send_row(rnd128(), 8'hB0);
    first_cyc = hs_cyc;
    send_row(rnd128(), 8'hB1);
    send_row(rnd128(), 8'hB2);
    send_row(rnd128(), 8'hB3);
    check("b2b_cycles", 32'(hs_cyc - first_cyc), 32'd3);
    drain();

    // reset in the middle of a four-row instruction
    send_inst(3, 0, 0, 3, 3, 4'hF);
    send_row(rnd128(), 8'hC0);
    send_row(rnd128(), 8'hC1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_valid", wrow_valid, 1'b0);
    check("rst_mid_winst_ready", winst_ready, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    expq.delete();
    rbuf_data = rnd128(); rbuf_valid = 1'b1;
    @(negedge clk);
    check("post_rst_winst_ready", winst_ready, 1'b1);
    repeat (3) begin
      check("post_rst_no_row", {wrow_valid, rbuf_ready}, 2'b00);
      @(negedge clk);
    end
    @(posedge clk); #1;
    rbuf_valid = 1'b0;

    // randomized instructions with random downstream backpressure
    rdy_rand = 1;
    for (int n = 0; n < 40; n++) begin
      int nrow;
      nrow = $urandom_range(0, 3);
      send_inst($urandom_range(0, 7), 1'($urandom), 1'($urandom), $urandom_range(0, 3),
                nrow, 4'($urandom));
      for (int r = 0; r <= nrow; r++) begin
        if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        send_row(rnd128(), 8'($urandom));
      end
    end
    @(posedge clk); #2;
    rdy_rand = 0; wrow_ready = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
